// File: rtl/aud_pkg.sv
// Shared types and constants for the audio transport controller and AudDSP.
package aud_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REC        = 3'd1,
        REC_PAUSE  = 3'd2,
        PLAY       = 3'd3,
        PLAY_PAUSE = 3'd4
    } aud_state_t;

    localparam logic [2:0] SPEED_MAX = 3'd7;
    localparam logic [2:0] SPEED_MIN = 3'd0;

    // Playback mode encodings, must match AudDSP's decode.
    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_FAST   = 2'd1;
    localparam logic [1:0] MODE_SLOW0  = 2'd2;
    localparam logic [1:0] MODE_SLOW1  = 2'd3;

endpackage

// File: rtl/aud_speed_ctrl.sv
// Saturating 0..7 playback speed counter driven by up/down key pulses.
module aud_speed_ctrl
    import aud_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_up,
    input  logic       i_dn,
    output logic [2:0] o_speed
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_speed <= SPEED_MIN;
        end else if (i_up && !i_dn && o_speed != SPEED_MAX) begin
            o_speed <= o_speed + 3'd1;
        end else if (i_dn && !i_up && o_speed != SPEED_MIN) begin
            o_speed <= o_speed - 3'd1;
        end
    end

endmodule

// File: rtl/aud_ctrl.sv
// Audio recorder/player transport sequencer and SRAM port mux.
// Define AUD_CTRL_LOOP_EN to restart playback from the start when the DSP reports done.
//
// state      | meaning
// IDLE       | stopped, nothing running
// REC        | recording, SRAM writes allowed
// REC_PAUSE  | recording paused, writes blocked
// PLAY       | DSP playing back
// PLAY_PAUSE | playback paused
module aud_ctrl
    import aud_pkg::*;
#(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(20'hFFFFF)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic              i_speed_up,
    input  logic              i_speed_dn,
    input  logic [1:0]        i_mode_sw,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic              i_rec_wen,
    input  logic [15:0]       i_rec_data,
    input  logic [ADDR_W-1:0] i_dsp_addr,
    input  logic              i_play_done,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic [2:0]        o_speed,
    output logic [1:0]        o_mode,
    output logic [ADDR_W-1:0] o_last_mem,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [15:0]       o_sram_wdata,
    output logic [2:0]        o_state
);

    aud_state_t        state, state_nxt;
    logic              rec_start_nxt, rec_pause_nxt, rec_stop_nxt;
    logic              dsp_start_nxt, dsp_pause_nxt, dsp_stop_nxt;
    logic [ADDR_W-1:0] last_mem_nxt;
    logic [1:0]        mode_nxt;
    logic              mem_full;

    aud_speed_ctrl u_speed (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_up    (i_speed_up),
        .i_dn    (i_speed_dn),
        .o_speed (o_speed)
    );

    assign mem_full = i_rec_wen && (i_rec_addr == MEM_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_rec_start <= 1'b0;
            o_rec_pause <= 1'b0;
            o_rec_stop  <= 1'b0;
            o_dsp_start <= 1'b0;
            o_dsp_pause <= 1'b0;
            o_dsp_stop  <= 1'b0;
            o_last_mem  <= '0;
            o_mode      <= MODE_NORMAL;
        end else begin
            state       <= state_nxt;
            o_rec_start <= rec_start_nxt;
            o_rec_pause <= rec_pause_nxt;
            o_rec_stop  <= rec_stop_nxt;
            o_dsp_start <= dsp_start_nxt;
            o_dsp_pause <= dsp_pause_nxt;
            o_dsp_stop  <= dsp_stop_nxt;
            o_last_mem  <= last_mem_nxt;
            o_mode      <= mode_nxt;
        end
    end

    // Keys that have no meaning in the current state fall through, so the
    // highest-priority key that actually acts is the one taken.
    always_comb begin
        state_nxt     = state;
        rec_start_nxt = 1'b0;
        rec_pause_nxt = 1'b0;
        rec_stop_nxt  = 1'b0;
        dsp_start_nxt = 1'b0;
        dsp_pause_nxt = 1'b0;
        dsp_stop_nxt  = 1'b0;
        last_mem_nxt  = o_last_mem;
        mode_nxt      = o_mode;
        case (state)
            IDLE: begin
                if (i_key_rec) begin
                    state_nxt     = REC;
                    rec_start_nxt = 1'b1;
                    last_mem_nxt  = '0;
                end else if (i_key_play && o_last_mem != '0) begin
                    state_nxt     = PLAY;
                    dsp_start_nxt = 1'b1;
                    mode_nxt      = i_mode_sw;
                end
            end
            REC: begin
                if (i_key_stop) begin
                    state_nxt    = IDLE;
                    rec_stop_nxt = 1'b1;
                    last_mem_nxt = i_rec_addr;
                end else if (mem_full) begin
                    state_nxt    = IDLE;
                    rec_stop_nxt = 1'b1;
                    last_mem_nxt = MEM_LAST;
                end else if (i_key_rec) begin
                    state_nxt     = REC_PAUSE;
                    rec_pause_nxt = 1'b1;
                end
            end
            REC_PAUSE: begin
                if (i_key_stop) begin
                    state_nxt    = IDLE;
                    rec_stop_nxt = 1'b1;
                    last_mem_nxt = i_rec_addr;
                end else if (i_key_rec) begin
                    state_nxt     = REC;
                    rec_start_nxt = 1'b1;
                end
            end
            PLAY: begin
                if (i_key_stop) begin
                    state_nxt    = IDLE;
                    dsp_stop_nxt = 1'b1;
                end else if (i_play_done) begin
`ifdef AUD_CTRL_LOOP_EN
                    dsp_start_nxt = 1'b1;
`else
                    state_nxt = IDLE;
`endif
                end else if (i_key_play) begin
                    state_nxt     = PLAY_PAUSE;
                    dsp_pause_nxt = 1'b1;
                end
            end
            PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_nxt    = IDLE;
                    dsp_stop_nxt = 1'b1;
                end else if (i_key_play) begin
                    state_nxt     = PLAY;
                    dsp_start_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_sram_addr  = (state == REC || state == REC_PAUSE) ? i_rec_addr : i_dsp_addr;
    assign o_sram_we_n  = ~(i_rec_wen && state == REC);
    assign o_sram_wdata = i_rec_data;
    assign o_state      = state;

endmodule

// File: tb/tb_aud_ctrl.sv
// Directed self-checking bench for aud_ctrl; honours AUD_CTRL_LOOP_EN when defined.
module tb_aud_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0;
    logic        speed_up = 1'b0, speed_dn = 1'b0;
    logic [1:0]  mode_sw = 2'd0;
    logic [19:0] rec_addr = '0;
    logic        rec_wen = 1'b0;
    logic [15:0] rec_data = '0;
    logic [19:0] dsp_addr = '0;
    logic        play_done = 1'b0;
    logic        rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop;
    logic [2:0]  speed;
    logic [1:0]  mode;
    logic [19:0] last_mem, sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_wdata;
    logic [2:0]  state;
    logic [5:0]  pulses;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign pulses = {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop};

    aud_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_key_rec(key_rec), .i_key_play(key_play), .i_key_stop(key_stop),
        .i_speed_up(speed_up), .i_speed_dn(speed_dn), .i_mode_sw(mode_sw),
        .i_rec_addr(rec_addr), .i_rec_wen(rec_wen), .i_rec_data(rec_data),
        .i_dsp_addr(dsp_addr), .i_play_done(play_done),
        .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
        .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
        .o_speed(speed), .o_mode(mode), .o_last_mem(last_mem),
        .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n),
        .o_sram_wdata(sram_wdata), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dsp_addr = 20'h0;
        tick();
        tick();
        rst_n = 1'b1;
        total_cnt++; if (state !== 3'd0) $display("FAIL reset_state got %0d exp 0", state); else pass_cnt++;
        total_cnt++; if (pulses !== 6'b0) $display("FAIL reset_pulses got %b exp 000000", pulses); else pass_cnt++;
        total_cnt++; if (speed !== 3'd0) $display("FAIL reset_speed got %0d exp 0", speed); else pass_cnt++;
        total_cnt++; if (mode !== 2'd0) $display("FAIL reset_mode got %0d exp 0", mode); else pass_cnt++;
        total_cnt++; if (last_mem !== 20'h0) $display("FAIL reset_last_mem got %h exp 0", last_mem); else pass_cnt++;
        total_cnt++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %b exp 1", sram_we_n); else pass_cnt++;
        total_cnt++; if (sram_addr !== 20'h0 || sram_wdata !== 16'h0)
            $display("FAIL reset_sram got addr %h data %h exp 0 0", sram_addr, sram_wdata); else pass_cnt++;
    endtask

    task automatic test_play_empty();
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
        total_cnt++; if (dsp_start !== 1'b0) $display("FAIL empty_play_start got %b exp 0", dsp_start); else pass_cnt++;
        total_cnt++; if (state !== 3'd0) $display("FAIL empty_play_state got %0d exp 0", state); else pass_cnt++;
    endtask

    task automatic test_record();
        int bad;
        bad = 0;
        key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        total_cnt++; if (rec_start !== 1'b1 || state !== 3'd1)
            $display("FAIL rec_start got pulse %b state %0d exp 1 1", rec_start, state); else pass_cnt++;
        tick();
        total_cnt++; if (rec_start !== 1'b0) $display("FAIL rec_start_width got %b exp 0", rec_start); else pass_cnt++;
        for (int i = 0; i < 500; i++) begin
            rec_addr = 20'((i * 291) / 499);
            rec_wen  = i[0];
            rec_data = 16'(i * 7);
            dsp_addr = 20'hABCDE;
            #1;
            if (sram_we_n !== ~rec_wen || sram_addr !== rec_addr || sram_wdata !== rec_data) bad++;
            tick();
        end
        total_cnt++; if (bad !== 0) $display("FAIL rec_write_mux got %0d bad cycles exp 0", bad); else pass_cnt++;
        rec_wen = 1'b0;
        rec_addr = 20'h00123;
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        total_cnt++; if (rec_stop !== 1'b1 || state !== 3'd0)
            $display("FAIL rec_stop got pulse %b state %0d exp 1 0", rec_stop, state); else pass_cnt++;
        total_cnt++; if (last_mem !== 20'h00123) $display("FAIL rec_last_mem got %h exp 00123", last_mem); else pass_cnt++;
        tick();
        total_cnt++; if (rec_stop !== 1'b0) $display("FAIL rec_stop_width got %b exp 0", rec_stop); else pass_cnt++;
        rec_wen = 1'b1;
        #1;
        total_cnt++; if (sram_we_n !== 1'b1 || sram_addr !== 20'hABCDE)
            $display("FAIL idle_write_block got we_n %b addr %h exp 1 abcde", sram_we_n, sram_addr); else pass_cnt++;
        rec_wen = 1'b0;
    endtask

    task automatic test_play();
        mode_sw = 2'd3;
        dsp_addr = 20'h00555;
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
        total_cnt++; if (dsp_start !== 1'b1 || state !== 3'd3 || mode !== 2'd3)
            $display("FAIL play_start got pulse %b state %0d mode %0d exp 1 3 3", dsp_start, state, mode); else pass_cnt++;
        total_cnt++; if (sram_addr !== 20'h00555) $display("FAIL play_addr got %h exp 00555", sram_addr); else pass_cnt++;
        tick();
        total_cnt++; if (dsp_start !== 1'b0) $display("FAIL play_start_width got %b exp 0", dsp_start); else pass_cnt++;
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
        total_cnt++; if (dsp_pause !== 1'b1 || state !== 3'd4)
            $display("FAIL play_pause got pulse %b state %0d exp 1 4", dsp_pause, state); else pass_cnt++;
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
        total_cnt++; if (pulses !== 6'b0 || state !== 3'd4)
            $display("FAIL pause_done_ignored got pulses %b state %0d exp 000000 4", pulses, state); else pass_cnt++;
        mode_sw = 2'd1;
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
        total_cnt++; if (dsp_start !== 1'b1 || state !== 3'd3 || mode !== 2'd3)
            $display("FAIL play_resume got pulse %b state %0d mode %0d exp 1 3 3", dsp_start, state, mode); else pass_cnt++;
        tick();
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
`ifdef AUD_CTRL_LOOP_EN
        total_cnt++; if (state !== 3'd3 || pulses !== 6'b000100)
            $display("FAIL play_done_loop got state %0d pulses %b exp 3 000100", state, pulses); else pass_cnt++;
        tick();
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        total_cnt++; if (dsp_stop !== 1'b1 || state !== 3'd0)
            $display("FAIL play_stop got pulse %b state %0d exp 1 0", dsp_stop, state); else pass_cnt++;
`else
        total_cnt++; if (state !== 3'd0 || pulses !== 6'b0)
            $display("FAIL play_done got state %0d pulses %b exp 0 000000", state, pulses); else pass_cnt++;
`endif
        tick();
    endtask

    task automatic test_speed();
        for (int i = 0; i < 7; i++) begin
            speed_up = 1'b1; tick(); speed_up = 1'b0; tick();
        end
        total_cnt++; if (speed !== 3'd7) $display("FAIL speed_up7 got %0d exp 7", speed); else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            speed_up = 1'b1; tick(); speed_up = 1'b0; tick();
        end
        total_cnt++; if (speed !== 3'd7) $display("FAIL speed_sat_hi got %0d exp 7", speed); else pass_cnt++;
        speed_up = 1'b1; speed_dn = 1'b1; tick(); speed_up = 1'b0; speed_dn = 1'b0;
        total_cnt++; if (speed !== 3'd7) $display("FAIL speed_both_hi got %0d exp 7", speed); else pass_cnt++;
        speed_dn = 1'b1; tick(); speed_dn = 1'b0;
        total_cnt++; if (speed !== 3'd6) $display("FAIL speed_dn1 got %0d exp 6", speed); else pass_cnt++;
        speed_up = 1'b1; speed_dn = 1'b1; tick(); speed_up = 1'b0; speed_dn = 1'b0;
        total_cnt++; if (speed !== 3'd6) $display("FAIL speed_both_mid got %0d exp 6", speed); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            speed_dn = 1'b1; tick(); speed_dn = 1'b0; tick();
        end
        total_cnt++; if (speed !== 3'd0) $display("FAIL speed_sat_lo got %0d exp 0", speed); else pass_cnt++;
    endtask

    task automatic test_rec_priority_full();
        rec_addr = 20'h00010;
        key_rec = 1'b1; key_play = 1'b1;
        tick();
        key_rec = 1'b0; key_play = 1'b0;
        total_cnt++; if (state !== 3'd1 || pulses !== 6'b100000 || last_mem !== 20'h0)
            $display("FAIL rec_over_play got state %0d pulses %b last %h exp 1 100000 0", state, pulses, last_mem); else pass_cnt++;
        tick();
        rec_addr = 20'h00042;
        key_stop = 1'b1; key_rec = 1'b1;
        tick();
        key_stop = 1'b0; key_rec = 1'b0;
        total_cnt++; if (state !== 3'd0 || pulses !== 6'b001000 || last_mem !== 20'h00042)
            $display("FAIL stop_over_rec got state %0d pulses %b last %h exp 0 001000 00042", state, pulses, last_mem); else pass_cnt++;
        tick();
        key_rec = 1'b1; tick(); key_rec = 1'b0; tick();
        key_rec = 1'b1; tick(); key_rec = 1'b0;
        total_cnt++; if (state !== 3'd2 || rec_pause !== 1'b1)
            $display("FAIL rec_pause got state %0d pulse %b exp 2 1", state, rec_pause); else pass_cnt++;
        rec_addr = 20'h00077;
        rec_wen = 1'b1;
        #1;
        total_cnt++; if (sram_we_n !== 1'b1 || sram_addr !== 20'h00077)
            $display("FAIL pause_write_block got we_n %b addr %h exp 1 00077", sram_we_n, sram_addr); else pass_cnt++;
        rec_wen = 1'b0;
        tick();
        key_rec = 1'b1; tick(); key_rec = 1'b0;
        total_cnt++; if (state !== 3'd1 || rec_start !== 1'b1)
            $display("FAIL rec_resume got state %0d pulse %b exp 1 1", state, rec_start); else pass_cnt++;
        tick();
        rec_addr = 20'hFFFFF;
        rec_wen = 1'b1;
        #1;
        total_cnt++; if (sram_we_n !== 1'b0) $display("FAIL full_write got we_n %b exp 0", sram_we_n); else pass_cnt++;
        tick();
        rec_wen = 1'b0;
        total_cnt++; if (state !== 3'd0 || pulses !== 6'b001000 || last_mem !== 20'hFFFFF)
            $display("FAIL full_stop got state %0d pulses %b last %h exp 0 001000 fffff", state, pulses, last_mem); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_play();
        speed_up = 1'b1; tick(); tick(); speed_up = 1'b0;
        mode_sw = 2'd2;
        key_play = 1'b1; tick(); key_play = 1'b0;
        total_cnt++; if (state !== 3'd3 || speed !== 3'd2 || mode !== 2'd2)
            $display("FAIL pre_reset_play got state %0d speed %0d mode %0d exp 3 2 2", state, speed, mode); else pass_cnt++;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++; if (state !== 3'd0 || speed !== 3'd0 || last_mem !== 20'h0 || mode !== 2'd0)
            $display("FAIL mid_reset got state %0d speed %0d last %h mode %0d exp 0 0 0 0", state, speed, last_mem, mode); else pass_cnt++;
        total_cnt++; if (pulses !== 6'b0) $display("FAIL mid_reset_pulses got %b exp 000000", pulses); else pass_cnt++;
        tick();
        total_cnt++; if (pulses !== 6'b0 || state !== 3'd0)
            $display("FAIL post_reset got pulses %b state %0d exp 000000 0", pulses, state); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_play_empty();
        test_record();
        test_play();
        test_speed();
        test_rec_priority_full();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
